adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CNTW, default 16, width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  requester 0/1 operation request, level, held until ack.
REQ-006 a0, b0, a1, b1  input  WIDTH each  requester operands.
REQ-007 cin0, cin1  input  1 each  requester carry-in.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-009 add_a, add_b  output  WIDTH each  operands driven to the shared external adder.
REQ-010 add_cin  output  1  carry-in driven to the shared adder.
REQ-011 add_sum  input  WIDTH, add_cout  input  1  shared adder result, combinational from add_a/add_b/add_cin.
REQ-012 sum  output  WIDTH, cout  output  1  registered result of last completed operation.
REQ-013 ovf  output  1  registered signed overflow of last completed operation.
REQ-014 res_id  output  1  requester index of last completed operation.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 ops_done  output  CNTW  count of completed operations.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; one-hot or binary encoding at implementer discretion.
REQ-018 IDLE: if req0|req1 at posedge, SHALL latch winner's a, b, cin into internal operand registers, record gnt, go EXEC; else stay IDLE.
REQ-019 Arbitration SHALL be round-robin: on simultaneous req0&req1, grant the requester not granted last; single request granted directly.
REQ-020 Last-grant pointer SHALL update only on entering RESP, not on grant.
REQ-021 add_a/add_b/add_cin SHALL always reflect the internal operand registers (never raw requester inputs).
REQ-022 EXEC: SHALL capture add_sum->sum, add_cout->cout, gnt->res_id, ovf=(A[MSB]==B[MSB])&&(add_sum[MSB]!=A[MSB]); go RESP.
REQ-023 RESP: ack of gnt SHALL be high for exactly this one cycle (combinational decode of state==RESP and gnt); other ack low; go IDLE.
REQ-024 Latency: request sampled at edge k -> ack high during cycle between edges k+2 and k+3; sum/cout/ovf/res_id valid from edge k+1 onward.
REQ-025 Throughput: at most one operation per 4 cycles; IDLE re-samples requests at edge k+4 earliest.
REQ-026 Requester SHALL drop req by the edge ending its ack cycle; req still high at the next IDLE sample is a new request.
REQ-027 Requests arriving while busy SHALL be ignored (not queued) until IDLE; operand changes during EXEC/RESP SHALL not affect the result.
REQ-028 sum/cout/ovf/res_id SHALL hold until the next EXEC capture.
REQ-029 ops_done SHALL increment by 1 on each entry into RESP and saturate at 2^CNTW-1 (no wrap).
REQ-030 Adder arithmetic is WIDTH-bit modulo; carry out beyond WIDTH appears only on cout.

Reset
REQ-031 rst high at posedge SHALL force: state IDLE, ack0=ack1=0, busy=0, sum=0, cout=0, ovf=0, res_id=0, ops_done=0, operand registers 0, last-grant pointer=1 (requester 0 wins first tie).
REQ-032 rst SHALL take priority over all other events, including mid-EXEC or mid-RESP; an interrupted operation produces no ack and no counter increment.
REQ-033 Requests held across reset deassertion SHALL be sampled at the first IDLE edge after rst low.

Verification
REQ-034 Single op: req0, a0=0x0000_0001, b0=0xFFFF_FFFF, cin0=0 -> ack0 at k+2, sum=0, cout=1, ovf=0, res_id=0, ops_done=1.
REQ-035 Overflow: req1, a1=0x7FFF_FFFF, b1=0x0000_0001, cin1=0 -> ack1, sum=0x8000_0000, cout=0, ovf=1, res_id=1.
REQ-036 Tie fairness: req0&req1 held continuously from reset, re-asserted after each ack -> grants alternate 0,1,0,1; acks never overlap.
REQ-037 Operand stability: change a0 to 0xDEAD_BEEF during EXEC of a0=5, b0=3 -> sum=8.
REQ-038 Reset mid-op: assert rst in EXEC -> no ack, busy=0, sum=0, ops_done=0 next cycle; request afterward completes normally.
REQ-039 Saturation: CNTW=2, run 5 ops -> ops_done reads 1,2,3,3,3.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder between two requesters.
// Latency: grant at sample edge k, result registered at k+1, ack during cycle k+2..k+3.
// Backpressure: requests are level-held; anything seen while busy is ignored until IDLE.
module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             res_id,
    output logic             busy,
    output logic [CNTW-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             exec_2nd;
    logic             gnt;
    logic             last_gnt;
    logic             pick;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

    // Tie goes to whoever did not complete last; a lone request wins outright.
    always_comb begin
        pick = req1;
        if (req0 && req1)
            pick = ~last_gnt;
    end

    assign add_a   = op_a;
    assign add_b   = op_b;
    assign add_cin = op_cin;

    assign ack0 = (state == RESP) && !gnt;
    assign ack1 = (state == RESP) &&  gnt;
    assign busy = (state != IDLE);

    // EXEC spans two cycles: the first edge captures the adder result, the
    // second enters RESP, so ack lands two cycles after the sampling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            exec_2nd <= 1'b0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            res_id   <= 1'b0;
            ops_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= pick;
                        op_a     <= pick ? a1 : a0;
                        op_b     <= pick ? b1 : b0;
                        op_cin   <= pick ? cin1 : cin0;
                        exec_2nd <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (!exec_2nd) begin
                        sum      <= add_sum;
                        cout     <= add_cout;
                        res_id   <= gnt;
                        ovf      <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                    (add_sum[WIDTH-1] != op_a[WIDTH-1]);
                        exec_2nd <= 1'b1;
                    end else begin
                        state    <= RESP;
                        last_gnt <= gnt;
                        if (ops_done != {CNTW{1'b1}})
                            ops_done <= ops_done + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
